demux4_scan_ctrl: RTL

//   Upstream sequencer for the 4-way 1-bit demux stage. Drives its select
//   (A[1:0]) and data (din) inputs to route one latched data bit to each

---
 rtl/demux4_scan_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/demux4_scan_ctrl.sv
// demux4_scan_ctrl: sequencer for a 4-way 1-bit demux. Routes a latched data
// bit to each enabled channel in ascending order, holding each channel for
// DWELL cycles. Channels are separated by a GAP-cycle break-before-make window,
// so the select never moves while din is high.
module demux4_scan_ctrl #(
  parameter int DWELL = 10,
  parameter int GAP   = 2,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  input  logic [3:0] ch_mask,
  input  logic       din_in,
  output logic [1:0] A,
  output logic       din,
  output logic       busy,
  output logic       ch_done,
  output logic       scan_done
);

  // The select update happens at the end of the first gap cycle and din rises
  // at the end of the last one, so a single-cycle gap would make them collide.
  if (GAP < 2) begin : g_bad_gap
    $error("demux4_scan_ctrl: GAP must be >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP, S_DONE} state_e;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic             data_q, data_d;
  logic [1:0]       a_q, a_d;
  logic             din_q, din_d;
  logic             busy_q, busy_d;
  logic             ch_done_q, ch_done_d;
  logic             scan_done_q, scan_done_d;
  logic             nxt_found;
  logic [1:0]       nxt_idx;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_set = 2'(i);
    end
  endfunction

  // Lowest enabled channel strictly above the current select.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (2'(i) > a_q)) begin
        nxt_found = 1'b1;
        nxt_idx   = 2'(i);
      end
    end
  end

  // Next state and next registered outputs; pulses default low.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    data_d      = data_q;
    a_d         = a_q;
    din_d       = din_q;
    busy_d      = busy_q;
    ch_done_d   = 1'b0;
    scan_done_d = 1'b0;
    if (stop) begin
      // Abort: select holds, no completion pulses for the cut-short channel.
      state_d = S_IDLE;
      cnt_d   = '0;
      din_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          din_d  = 1'b0;
          busy_d = 1'b0;
          if (start) begin
            if (ch_mask != 4'd0) begin
              mask_d  = ch_mask;
              data_d  = din_in;
              a_d     = lowest_set(ch_mask);
              din_d   = din_in;
              busy_d  = 1'b1;
              cnt_d   = '0;
              state_d = S_DRIVE;
            end else begin
              scan_done_d = 1'b1;
            end
          end
        end
        S_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d     = '0;
            din_d     = 1'b0;
            ch_done_d = 1'b1;
            if (nxt_found) begin
              state_d = S_GAP;
            end else if (loop) begin
              state_d     = S_GAP;
              scan_done_d = 1'b1;
            end else begin
              state_d     = S_DONE;
              scan_done_d = 1'b1;
              busy_d      = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          // Move the select one edge after din fell; wrap to lowest if none above.
          if (cnt_q == '0) a_d = nxt_found ? nxt_idx : lowest_set(mask_q);
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            din_d   = data_q;
            state_d = S_DRIVE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mask_q      <= 4'd0;
      data_q      <= 1'b0;
      a_q         <= 2'd0;
      din_q       <= 1'b0;
      busy_q      <= 1'b0;
      ch_done_q   <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      a_q         <= a_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      ch_done_q   <= ch_done_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign A         = a_q;
  assign din       = din_q;
  assign busy      = busy_q;
  assign ch_done   = ch_done_q;
  assign scan_done = scan_done_q;

endmodule
